// File: rtl/gray_counter_if.sv
// Gray counter bus: control inputs and registered count outputs.
// Optional GRAY_STEP_CHECK_EN adds the step_err self-check output.
interface gray_counter_if #(
  parameter int unsigned data_width = 4
);
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [data_width-1:0] load_val;
  logic [data_width-1:0] d_out;
  logic [data_width-1:0] bin_out;
  logic                  wrap;
`ifdef GRAY_STEP_CHECK_EN
  logic                  step_err;

  modport master (
    output en, up_dn, load, load_val,
    input  d_out, bin_out, wrap, step_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output d_out, bin_out, wrap, step_err
  );
`else
  modport master (
    output en, up_dn, load, load_val,
    input  d_out, bin_out, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output d_out, bin_out, wrap
  );
`endif
endinterface

// File: rtl/gray_counter.sv
// Synchronous up/down Gray-code counter with load and wrap pulse.
// d_out is encoded from the next binary value before the flop, so it never glitches.
// Optional macro GRAY_STEP_CHECK_EN adds a registered Hamming-distance monitor (step_err).
module gray_counter #(
  parameter int unsigned data_width = 4
) (
  input logic           clk,
  input logic           rst_n,
  gray_counter_if.slave bus
);

  logic [data_width-1:0] cnt_q, cnt_d;
  logic [data_width-1:0] gray_q, gray_d;
  logic                  wrap_q, wrap_d;

  // Next-state: load beats enable; wrap only on an enabled step across the boundary.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        cnt_d  = cnt_q + data_width'(1);
        wrap_d = (cnt_q == '1);
      end else begin
        cnt_d  = cnt_q - data_width'(1);
        wrap_d = (cnt_q == '0);
      end
    end
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  // Count, Gray and wrap registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.d_out   = gray_q;
  assign bus.bin_out = cnt_q;
  assign bus.wrap    = wrap_q;

`ifdef GRAY_STEP_CHECK_EN
  // Kind of edge that produced the current d_out; load/reset edges are not checked.
  typedef enum logic [1:0] {KindExempt, KindStep, KindHold} kind_e;

  kind_e                 kind_q, kind_d;
  logic [data_width-1:0] gray_prev_q;
  logic                  step_err_q, step_err_d;
  int unsigned           dist;

  function automatic int unsigned popcnt(input logic [data_width-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < int'(data_width); i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

  // Classify this edge and judge the distance between the last two d_out values.
  always_comb begin
    kind_d     = KindHold;
    step_err_d = 1'b0;
    if (bus.load) begin
      kind_d = KindExempt;
    end else if (bus.en) begin
      kind_d = KindStep;
    end
    dist = popcnt(gray_q ^ gray_prev_q);
    unique case (kind_q)
      KindStep: step_err_d = (dist != 1);
      KindHold: step_err_d = (dist != 0);
      default:  step_err_d = 1'b0;
    endcase
  end

  // Monitor registers; reset leaves the first post-reset edge exempt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind_q      <= KindExempt;
      gray_prev_q <= '0;
      step_err_q  <= 1'b0;
    end else begin
      kind_q      <= kind_d;
      gray_prev_q <= gray_q;
      step_err_q  <= step_err_d;
    end
  end

  assign bus.step_err = step_err_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter (data_width = 4).
module tb_gray_counter;
  localparam int unsigned W    = 4;
  localparam int          Mask = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  gray_counter_if #(.data_width(W)) bus ();
  gray_counter #(.data_width(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
    logic         wrap;
    logic         is_step;
    logic         is_hold;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           m_cnt    = 0;
  logic [W-1:0] prev_gray;

  // Gray sequence after each up step from 0 (16th wraps to 0).
  logic [3:0] up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                              4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                              4'b1011, 4'b1001, 4'b1000, 4'b0000};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, push model prediction, compare just after posedge.
  task automatic cycle(input logic r, input logic e, input logic u, input logic ld,
                       input logic [W-1:0] v);
    exp_t x;
    int   g;
    @(negedge clk);
    rst_n        = r;
    bus.en       = e;
    bus.up_dn    = u;
    bus.load     = ld;
    bus.load_val = v;
    prev_gray    = bus.d_out;
    x = '0;
    if (!r) begin
      m_cnt = 0;
    end else if (ld) begin
      m_cnt = int'(v);
    end else if (e) begin
      x.is_step = 1'b1;
      if (u) begin
        x.wrap = (m_cnt == Mask);
        m_cnt  = (m_cnt + 1) & Mask;
      end else begin
        x.wrap = (m_cnt == 0);
        m_cnt  = (m_cnt - 1) & Mask;
      end
    end else begin
      x.is_hold = 1'b1;
    end
    g      = m_cnt ^ (m_cnt >> 1);
    x.gray = g[W-1:0];
    x.bin  = m_cnt[W-1:0];
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq("d_out", 32'(bus.d_out), 32'(x.gray));
    check_eq("bin_out", 32'(bus.bin_out), 32'(x.bin));
    check_eq("wrap", 32'(bus.wrap), 32'(x.wrap));
    if (x.is_step) check_eq("one_bit_step", 32'($countones(bus.d_out ^ prev_gray)), 32'd1);
    if (x.is_hold) check_eq("hold_same", 32'(bus.d_out), 32'(prev_gray));
`ifdef GRAY_STEP_CHECK_EN
    check_eq("step_err", 32'(bus.step_err), 32'd0);
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;

    // Reset held with enable high.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    check_eq("reset_d_out", 32'(bus.d_out), 32'd0);

    // Full up count including the wrap edge.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      check_eq("up_seq", 32'(bus.d_out), 32'(up_seq[i]));
    end
    check_eq("up_wrap", 32'(bus.wrap), 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    check_eq("wrap_one_cycle", 32'(bus.wrap), 32'd0);

    // Load beats enable.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101);
    check_eq("load_gray", 32'(bus.d_out), 32'b1011);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    check_eq("after_load_gray", 32'(bus.d_out), 32'b1001);

    // Load of 0 (the wrapped value) must not pulse wrap; then down wrap.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
    check_eq("load_no_wrap", 32'(bus.wrap), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check_eq("down_wrap_gray", 32'(bus.d_out), 32'b1000);
    check_eq("down_wrap_pulse", 32'(bus.wrap), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check_eq("down_next_gray", 32'(bus.d_out), 32'b1001);

    // Reach count 5, hold with up_dn toggling, then reset mid-operation.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    check_eq("count5_gray", 32'(bus.d_out), 32'b0111);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'(i), 1'b0, 4'h0);
      check_eq("hold_gray", 32'(bus.d_out), 32'b0111);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hf);
    check_eq("mid_reset_gray", 32'(bus.d_out), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    check_eq("resume_gray", 32'(bus.d_out), 32'b0001);

    // Mixed random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous Gray-code counter; the stage directly upstream of gray_to_binary.
- Produces a registered, glitch-free Gray-coded count on d_out. The downstream converter's d_in connects straight to d_out.
- Used for pointer/position generation where only one bit may change per step (FIFO pointers, CDC-safe counts).
- Also exposes the binary equivalent and a wrap pulse for local control logic.

Parameters:
- data_width, 4, counter width in bits for both Gray and binary outputs; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- en  input  1  count enable; when high, the counter steps one position per clock.
- up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_val  input  data_width  binary value to load.
- d_out  output  data_width  registered Gray-coded count.
- bin_out  output  data_width  registered binary count; always equals gray_to_binary(d_out).
- wrap  output  1  registered one-cycle pulse on wrap-around.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is synchronous and active-low.
- Reset state (rst_n=0 at a rising edge): bin_out=0, d_out=0, wrap=0. This state holds every cycle while rst_n=0.
- Priority per clock edge: reset > load > en > hold.
- Internal state: binary register cnt. Next value:
  - load: load_val
  - en & up_dn: cnt+1, modulo 2^data_width
  - en & !up_dn: cnt-1, modulo 2^data_width
  - otherwise: cnt
- Outputs:
  - d_out is registered from the next binary value: d_out <= nxt ^ (nxt >> 1).
  - Gray encoding is never computed combinationally after the flop, so d_out has no glitches.
  - bin_out <= nxt.
- Latency: one cycle. A change in en, up_dn or load_val is visible on the outputs after the next rising edge.
- Single-bit property:
  - On every en-driven step, including wrap-around, exactly one bit of d_out toggles.
  - On load, any number of bits may change.
- wrap:
  - Asserts for exactly one cycle when an en step takes cnt from 2^data_width-1 to 0 (up) or from 0 to 2^data_width-1 (down).
  - Asserts in the same cycle d_out shows the wrapped value.
  - Load never asserts wrap, even if the loaded value equals the wrapped value.
- load with en=1 in the same cycle: the load wins. No step occurs and wrap=0.
- up_dn toggling while en=0 has no effect.
- Reset mid-count: the state is cleared on the next edge with rst_n=0. The count resumes from 0 at the first edge after rst_n returns to 1, if en=1.
- All outputs are driven directly from flops; there is no combinational input-to-output path.

Optional Feature:
- Macro: GRAY_STEP_CHECK_EN.
- Defined:
  - Adds output step_err (1 bit, reset 0).
  - A registered monitor compares the previous and current d_out.
  - step_err pulses high for one cycle if the Hamming distance between them is not exactly 1 after an en step.
  - step_err is also checked for distance 0 after a hold cycle, i.e. the value must be unchanged.
  - Load and reset cycles are exempt.
  - step_err is sticky-free and must never fire in correct operation. It exists for silicon/FPGA self-check.
- Not defined: no step_err port and no monitor logic. The remaining behaviour is identical.

Test Plan (data_width=4):
- Reset: hold rst_n=0 for 3 clocks with en=1 -> d_out=0000, bin_out=0000, wrap=0 on every cycle.
- Full up count: rst_n=1, en=1, up_dn=1 for 16 clocks.
  - d_out steps 0000, 0001, 0011, 0010, 0110, … and reaches 1000 at count 15.
  - The 16th edge gives d_out=0000 and wrap=1 for one cycle.
  - Exactly one bit changes per step.
- Load: load=1, load_val=1101 (en=1 simultaneously) -> next cycle d_out=1011, bin_out=1101, wrap=0. The following up step gives d_out=1001 (binary 1110).
- Down wrap: from count 0, en=1, up_dn=0 -> d_out=1000, bin_out=1111, wrap=1. The next step gives d_out=1001 (binary 1110), wrap=0.
- Hold and reset mid-operation: at count 5 (d_out=0111), en=0 for 4 cycles -> d_out stays 0111. Then rst_n=0 for one edge -> 0000. Then en=1 -> 0001.
- With GRAY_STEP_CHECK_EN defined: run all of the above -> step_err stays 0 throughout.
